// File: rtl/fir_coeff_loader.sv
// Serial coefficient loader: fills a shadow bank over valid/ready, then commits it atomically.
// Optional idle-beat timeout in LOAD is compiled in with FIR_COEFF_LOADER_TIMEOUT_EN.
module fir_coeff_loader #(
    parameter int unsigned COEFF_WIDTH    = 8,
    parameter int unsigned NUM_TAPS       = 4,
    parameter logic [COEFF_WIDTH*NUM_TAPS-1:0] DEFAULT_COEFFS = {8'd4, 8'd3, -8'd1, -8'd2},
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            load_start_i,
    input  logic [COEFF_WIDTH-1:0]          coeff_in_i,
    input  logic                            coeff_valid_i,
    output logic                            coeff_ready_o,
    output logic                            load_busy_o,
    output logic                            load_done_o,
    output logic                            load_error_o,
    output logic                            coeff_update_o,
    output logic [COEFF_WIDTH*NUM_TAPS-1:0] packed_coeffs_o
);

    localparam int unsigned BankW = COEFF_WIDTH * NUM_TAPS;
    localparam int unsigned IdxW  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCommit
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [BankW-1:0]  shadow_q, shadow_d;
    logic [BankW-1:0]  packed_q, packed_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              update_q, update_d;

`ifdef FIR_COEFF_LOADER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    logic [TmoW-1:0]   tmo_q, tmo_d;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            shadow_q <= '0;
            packed_q <= DEFAULT_COEFFS;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            update_q <= 1'b0;
`ifdef FIR_COEFF_LOADER_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            packed_q <= packed_d;
            done_q   <= done_d;
            error_q  <= error_d;
            update_q <= update_d;
`ifdef FIR_COEFF_LOADER_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        packed_d = packed_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        update_d = 1'b0;
`ifdef FIR_COEFF_LOADER_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (load_start_i) begin
                    state_d = StLoad;
                    idx_d   = '0;
`ifdef FIR_COEFF_LOADER_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end

            StLoad: begin
                // A restart wins over a beat presented in the same cycle; that beat is dropped.
                if (load_start_i) begin
                    error_d = 1'b1;
                    idx_d   = '0;
`ifdef FIR_COEFF_LOADER_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else if (coeff_valid_i) begin
                    shadow_d[int'(idx_q)*COEFF_WIDTH +: COEFF_WIDTH] = coeff_in_i;
`ifdef FIR_COEFF_LOADER_TIMEOUT_EN
                    tmo_d = '0;
`endif
                    if (idx_q == LastIdx) begin
                        state_d = StCommit;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
`ifdef FIR_COEFF_LOADER_TIMEOUT_EN
                end else if (tmo_q == TmoLast) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                    idx_d   = '0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end

            StCommit: begin
                packed_d = shadow_q;
                done_d   = 1'b1;
                update_d = 1'b1;
                state_d  = StIdle;
                idx_d    = '0;
            end

            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    assign coeff_ready_o   = (state_q == StLoad);
    assign load_busy_o     = (state_q == StLoad) || (state_q == StCommit);
    assign load_done_o     = done_q;
    assign load_error_o    = error_q;
    assign coeff_update_o  = update_q;
    assign packed_coeffs_o = packed_q;

    a_params_legal: assert property (@(posedge clk_i)
        (NUM_TAPS >= 2) && (TIMEOUT_CYCLES >= 1));

    a_done_error_excl: assert property (@(posedge clk_i) disable iff (rst_i)
        !(load_done_o && load_error_o));

    a_update_with_done: assert property (@(posedge clk_i)
        coeff_update_o == load_done_o);

    // Outside reset, the filter-facing set may only move together with the update strobe.
    a_packed_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        $changed(packed_coeffs_o) |-> (coeff_update_o || $past(rst_i)));

endmodule
